bpsk_demod: RTL and testbench

//  Receive side of the BPSK link. Takes the 8-bit sampled modulated waveform that the modulator emits
//  (carrier, or inverted carrier, per bit). Correlates each bit period against a local reference carrier
//  and slices the sign to recover the bit. Deserialises FRAME_BITS recovered bits MSB-first into a parallel word.

---
 rtl/bpsk_pkg.sv | 47 ++++
 rtl/bpsk_demod_if.sv | 24 ++
 rtl/bpsk_carrier_lut.sv | 20 ++
 rtl/bpsk_demod.sv | 119 +++++++++++
 tb/tb_bpsk_demod.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: midscale, the carrier table generator used by the modulator
// and demodulator, and the receiver state encoding.
package bpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

  // Fixed-point Q28 scale for the elaboration-time sine evaluation
  localparam longint ONE_Q  = 64'sd268435456;
  localparam longint HALF_Q = 64'sd134217728;
  localparam longint PI_Q   = 64'sd843314857;

  function automatic int midscale(input int data_w);
    return 1 << (data_w - 1);
  endfunction

  // round(MID + (MID-1)*sin(2*pi*k/n)); quarter-wave symmetry keeps the Taylor series on [0, pi/2]
  function automatic int carrier_sample(input int k, input int n, input int data_w);
    int     mid;
    int     quarter;
    int     quad;
    int     m;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint mag;
    mid     = midscale(data_w);
    quarter = n / 4;
    quad    = k / quarter;
    m       = k % quarter;
    if (quad == 1 || quad == 3) m = quarter - m;
    x    = (longint'(m) * 2 * PI_Q) / longint'(n);
    x2   = (x * x) / ONE_Q;
    term = x;
    sum  = x;
    for (int i = 1; i <= 7; i++) begin
      term = -((term * x2) / ONE_Q) / longint'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    mag = (longint'(mid - 1) * sum + HALF_Q) / ONE_Q;
    return (quad >= 2) ? mid - int'(mag) : mid + int'(mag);
  endfunction

endpackage

// File: rtl/bpsk_demod_if.sv
// Sample-in / bit-and-word-out bundle of the BPSK receiver.
interface bpsk_demod_if #(
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = 8
);
  logic                  start;
  logic [DATA_W-1:0]     sample_in;
  logic                  sample_valid;
  logic                  bit_out;
  logic                  bit_valid;
  logic [FRAME_BITS-1:0] data_out;
  logic                  data_valid;
  logic                  busy;

  modport master (
    output start, sample_in, sample_valid,
    input  bit_out, bit_valid, data_out, data_valid, busy
  );

  modport slave (
    input  start, sample_in, sample_valid,
    output bit_out, bit_valid, data_out, data_valid, busy
  );
endinterface

// File: rtl/bpsk_carrier_lut.sv
// One-cycle carrier ROM: phase index to offset-binary reference sample.
module bpsk_carrier_lut
  import bpsk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 16
) (
  input  logic [$clog2(N)-1:0] i_phase,
  output logic [DATA_W-1:0]    o_ref
);

  logic [DATA_W-1:0] w_rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    assign w_rom[k] = DATA_W'(carrier_sample(k, N, DATA_W));
  end

  assign o_ref = w_rom[i_phase];

endmodule

// File: rtl/bpsk_demod.sv
// BPSK receiver: per-bit correlation against the local carrier, sign slicer,
// MSB-first deserialiser and the IDLE/ACQ frame controller.
module bpsk_demod
  import bpsk_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int SAMPLES_PER_BIT = 16,
  parameter int FRAME_BITS      = 8
) (
  input  logic            clk,
  input  logic            reset,
  bpsk_demod_if.slave     bus
);

  localparam int ACC_W = 2 * DATA_W + $clog2(SAMPLES_PER_BIT);
  localparam int SW    = DATA_W + 1;
  localparam int PH_W  = $clog2(SAMPLES_PER_BIT);
  localparam int BC_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int MID   = midscale(DATA_W);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [PH_W-1:0]          r_phase;
  logic [BC_W-1:0]          r_bit_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [FRAME_BITS-1:0]    r_shift;
  logic                     r_bit_out;
  logic                     r_bit_valid;
  logic [FRAME_BITS-1:0]    r_data_out;
  logic                     r_data_valid;

  logic [DATA_W-1:0]        w_ref;
  logic signed [SW-1:0]     w_s;
  logic signed [SW-1:0]     w_r;
  logic signed [2*SW-1:0]   w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic                     w_accept;
  logic                     w_bit_end;
  logic                     w_frame_end;
  logic                     w_bit;
  logic [FRAME_BITS-1:0]    w_shift_next;

  bpsk_carrier_lut #(
    .DATA_W (DATA_W),
    .N      (SAMPLES_PER_BIT)
  ) u_lut (
    .i_phase (r_phase),
    .o_ref   (w_ref)
  );

  // A start pulse owns its cycle: any sample arriving alongside it is dropped
  assign w_accept     = bus.sample_valid && (r_state == ACQ) && !bus.start;
  assign w_s          = $signed({1'b0, bus.sample_in}) - SW'(MID);
  assign w_r          = $signed({1'b0, w_ref}) - SW'(MID);
  assign w_prod       = w_s * w_r;
  assign w_acc_next   = r_acc + ACC_W'(w_prod);
  assign w_bit_end    = w_accept && (r_phase == PH_W'(SAMPLES_PER_BIT - 1));
  assign w_frame_end  = w_bit_end && (r_bit_cnt == BC_W'(FRAME_BITS - 1));
  assign w_bit        = ~w_acc_next[ACC_W-1];
  assign w_shift_next = {r_shift[FRAME_BITS-2:0], w_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: the default assignment first means every path drives w_state_next, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (bus.start)        w_state_next = ACQ;
    else if (w_frame_end) w_state_next = IDLE;
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase      <= '0;
      r_bit_cnt    <= '0;
      r_acc        <= '0;
      r_shift      <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_bit_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      if (bus.start) begin
        r_phase   <= '0;
        r_bit_cnt <= '0;
        r_acc     <= '0;
        r_shift   <= '0;
      end else if (w_accept) begin
        if (w_bit_end) begin
          r_acc       <= '0;
          r_phase     <= '0;
          r_bit_out   <= w_bit;
          r_bit_valid <= 1'b1;
          r_shift     <= w_shift_next;
          r_bit_cnt   <= w_frame_end ? '0 : r_bit_cnt + BC_W'(1);
          if (w_frame_end) begin
            r_data_out   <= w_shift_next;
            r_data_valid <= 1'b1;
          end
        end else begin
          r_acc   <= w_acc_next;
          r_phase <= r_phase + PH_W'(1);
        end
      end
    end
  end

  assign bus.bit_out    = r_bit_out;
  assign bus.bit_valid  = r_bit_valid;
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_bpsk_demod.sv
// Directed + randomized bench for bpsk_demod; ideal carrier built from $sin, expected bits
// are simply the transmitted bits.
module tb_bpsk_demod;

  localparam int DATA_W = 8;
  localparam int SPB    = 16;
  localparam int FB     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bpsk_demod_if #(.DATA_W(DATA_W), .FRAME_BITS(FB)) bus ();

  bpsk_demod #(
    .DATA_W          (DATA_W),
    .SAMPLES_PER_BIT (SPB),
    .FRAME_BITS      (FB)
  ) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tbl [SPB];
  logic got_bits [$];
  logic exp_bits [$];
  logic [FB-1:0] got_words [$];
  int   strobe_err = 0;
  logic prev_bv = 1'b0;
  logic prev_dv = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.bit_valid) got_bits.push_back(bus.bit_out);
    if (bus.data_valid) got_words.push_back(bus.data_out);
    if (bus.bit_valid && prev_bv) strobe_err++;
    if (bus.data_valid && prev_dv) strobe_err++;
    prev_bv = bus.bit_valid;
    prev_dv = bus.data_valid;
  endtask

  task automatic idle_cycle();
    bus.sample_valid = 1'b0;
    bus.sample_in    = 8'($urandom);
    tick();
  endtask

  // Start pulse carries a junk valid sample that must be ignored
  task automatic pulse_start();
    bus.start        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'($urandom);
    tick();
    bus.start        = 1'b0;
    bus.sample_valid = 1'b0;
  endtask

  // gap_mode: 0 = continuous, 1 = idle clk before every sample, 2 = random idles
  task automatic send_frame(input logic [FB-1:0] word, input int nbits, input int noise,
                            input int gap_mode);
    int s;
    logic b;
    for (int bi = 0; bi < nbits; bi++) begin
      b = word[FB-1-bi];
      exp_bits.push_back(b);
      for (int k = 0; k < SPB; k++) begin
        if (gap_mode == 1) idle_cycle();
        if (gap_mode == 2 && ($urandom % 3) == 0) idle_cycle();
        s = b ? tbl[k] : 256 - tbl[k];
        if (noise > 0) s = s + int'($urandom_range(2 * noise)) - noise;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        bus.sample_in    = 8'(s);
        bus.sample_valid = 1'b1;
        tick();
      end
    end
    bus.sample_valid = 1'b0;
    if (nbits == FB) begin
      check("dv_latency", 32'(bus.data_valid), 32'd1);
      check("bv_coincident", 32'(bus.bit_valid), 32'd1);
      check("busy_fall", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic check_frame(input string tag, input logic [FB-1:0] exp_word);
    check({tag, "_nbits"}, 32'(got_bits.size()), 32'(exp_bits.size()));
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
      check({tag, "_bit"}, 32'(got_bits[i]), 32'(exp_bits[i]));
    check({tag, "_nwords"}, 32'(got_words.size()), 32'd1);
    if (got_words.size() > 0) check({tag, "_word"}, 32'(got_words[0]), 32'(exp_word));
    got_bits.delete();
    exp_bits.delete();
    got_words.delete();
  endtask

  initial begin
    logic [FB-1:0] w;
    for (int k = 0; k < SPB; k++)
      tbl[k] = int'(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / real'(SPB)));

    bus.start        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;

    // Carrier table in the package matches an independent sine evaluation
    for (int k = 0; k < SPB; k++)
      check("lut_entry", 32'(bpsk_pkg::carrier_sample(k, SPB, DATA_W)), 32'(tbl[k]));

    // 1: reset values, then 8'h99
    repeat (3) tick();
    check("rst_bit_out", 32'(bus.bit_out), 32'd0);
    check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    // Samples in IDLE produce nothing
    for (int i = 0; i < 20; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 8'($urandom);
      tick();
    end
    bus.sample_valid = 1'b0;
    check("idle_no_bits", 32'(got_bits.size()), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    pulse_start();
    check("start_busy", 32'(bus.busy), 32'd1);
    send_frame(8'h99, FB, 0, 0);
    check_frame("f99", 8'h99);

    // 2: back-to-back 8'h00 then 8'hFF, busy low for exactly one clk
    pulse_start();
    send_frame(8'h00, FB, 0, 0);
    check("b2b_gap_busy", 32'(bus.busy), 32'd0);
    pulse_start();
    check("b2b_busy_back", 32'(bus.busy), 32'd1);
    check_frame("f00", 8'h00);
    send_frame(8'hFF, FB, 0, 0);
    check_frame("fFF", 8'hFF);

    // 3: sample_valid toggling
    pulse_start();
    send_frame(8'hA5, FB, 0, 1);
    check_frame("fA5", 8'hA5);

    // 4: abort after 3 bits, restart with 8'hC3
    pulse_start();
    send_frame(8'h3C, 3, 0, 0);
    pulse_start();
    send_frame(8'hC3, FB, 0, 0);
    check_frame("fC3", 8'hC3);

    // 5: midscale ties slice to 1, then noisy 8'h5A
    pulse_start();
    for (int i = 0; i < FB * SPB; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 8'd128;
      tick();
    end
    bus.sample_valid = 1'b0;
    for (int i = 0; i < FB; i++) exp_bits.push_back(1'b1);
    check_frame("fmid", 8'hFF);
    pulse_start();
    send_frame(8'h5A, FB, 40, 0);
    check_frame("f5A", 8'h5A);

    // Random words, noise and gaps
    for (int t = 0; t < 4; t++) begin
      w = FB'($urandom);
      pulse_start();
      send_frame(w, FB, int'($urandom_range(40)), 2);
      check_frame("frand", w);
    end

    // 6: asynchronous reset mid-bit in the third bit
    pulse_start();
    send_frame(8'hFF, 2, 0, 0);
    send_frame(8'h00, 1, 0, 0);
    check("pre_rst_bit_out", 32'(bus.bit_out), 32'd0);
    got_bits.delete();
    exp_bits.delete();
    pulse_start();
    send_frame(8'hE0, 2, 0, 0);
    for (int k = 0; k < 7; k++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 8'(tbl[k]);
      tick();
    end
    bus.sample_valid = 1'b0;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    check("pre_rst_bit_hi", 32'(bus.bit_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_bit_out", 32'(bus.bit_out), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_data_out", 32'(bus.data_out), 32'd0);
    check("async_bit_valid", 32'(bus.bit_valid), 32'd0);
    tick();
    rst = 1'b0;
    got_bits.delete();
    exp_bits.delete();
    got_words.delete();
    tick();
    pulse_start();
    send_frame(8'h81, FB, 0, 0);
    check_frame("f81", 8'h81);

    repeat (3) tick();
    check("strobe_width", 32'(strobe_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the whole run is a few thousand clocks
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
